uart_tx_frame: RTL and testbench
================================

// Module: uart_tx_frame
// PURPOSE
//  UART transmit path: the counterpart of the RX parity-check/deserialiser chain.
//  - Accepts one parallel word per handshake.
//  - Serialises it LSB-first as: start bit, DATA_WIDTH data bits, optional parity bit, one stop bit.
//  - Each bit is held for Prescale clocks. Parity convention is identical to RX: Par_Typ=0 even, 1 odd.
// PARAMETERS
//  DATA_WIDTH  8  payload bits per frame
//  PRESC_W     6  width of Prescale input
// PORTS
//  Clk         in   1           system clock
//  Rst         in   1           asynchronous reset, active-low
//  P_Data      in   DATA_WIDTH  word to transmit
//  Data_Valid  in   1           request; accepted only when Busy=0
//  Par_En      in   1           1 = insert parity bit after data
//  Par_Typ     in   1           0 = even (bit=^data), 1 = odd (bit=~^data)
//  Prescale    in   PRESC_W     clocks per bit; 0 is treated as 1
//  Tx_Out      out  1           serial line, idle high
//  Busy        out  1           1 from accept until frame complete
// BEHAVIOUR
//  - Reset (async, any time incl. mid-frame): state=IDLE, Tx_Out=1, Busy=0, counters=0, frame abandoned.
//  - All outputs are registered. No combinational path from inputs to Tx_Out/Busy.
//  - Accept: on a rising edge with Data_Valid=1 and Busy=0:
//    - Latch P_Data, Par_En, Par_Typ and max(Prescale,1).
//    - Compute the parity bit from the latched word.
//    - Same edge: state=START, Tx_Out<=0, Busy<=1.
//    - Inputs are not sampled again until the next accept. Data_Valid while Busy=1 is ignored (no queuing).
//  - FSM: IDLE -> START -> DATA -> (PARITY if latched Par_En) -> STOP -> IDLE.
//  - Bit timer: counts 0..P-1, where P = latched prescale.
//    - On the edge where the count reaches P-1, it wraps to 0 and the next bit is driven.
//    - Every bit is therefore exactly P cycles.
//  - DATA: bit index 0..DATA_WIDTH-1; Tx_Out=data[idx], LSB first. Leave after index DATA_WIDTH-1 completes.
//  - PARITY: Tx_Out = even ? ^data : ~^data.
//  - STOP: Tx_Out=1 for P cycles. On the final edge: state=IDLE, Busy<=0, Tx_Out stays 1.
//  - Frame length in cycles: P*(DATA_WIDTH+2+Par_En), from the accept edge to the Busy-fall edge.
//  - Back-to-back: the next accept is possible at the first edge with Busy=0.
//    This gives one idle-high cycle minimum between frames.
//  - Prescale changing mid-frame has no effect on the current frame.
// TESTING
//  1. Reset: Rst=0 then released, no request -> Tx_Out=1, Busy=0 held for 20 cycles.
//  2. P_Data=8'hA5, Par_En=1, Par_Typ=0, Prescale=1:
//     -> Tx_Out sequence 0,1,0,1,0,0,1,0,1,0,1 (parity 0); Busy=1 for 11 cycles.
//  3. Same frame with Par_Typ=1 -> parity bit 1, all other bits unchanged.
//  4. P_Data=8'h0F, Par_En=0, Prescale=4:
//     -> start low 4 clk, then 1111 0000 each 4 clk, stop high 4 clk; Busy=1 exactly 40 cycles.
//  5. Data_Valid held high with P_Data changing during a frame:
//     -> frame carries the word latched at accept; next accept occurs at the first Busy=0 edge.
//  6. Rst asserted during DATA bit 3 -> Tx_Out=1 and Busy=0 immediately.
//     After release, a new 8'h3C frame is sent correctly. Also cover Prescale=0 behaving as 1.

Source files
------------

// File: rtl/uart_tx_frame.sv
// uart_tx_frame: UART transmit serialiser.
//   Accepts one parallel word per Data_Valid handshake while idle and sends it
//   LSB-first as start bit, DATA_WIDTH data bits, optional parity bit and one
//   stop bit. Each bit lasts Prescale clocks (0 treated as 1).
// Ports:
//   Clk        system clock
//   Rst        asynchronous reset, active-low
//   P_Data     word to transmit (sampled on accept)
//   Data_Valid transmit request, accepted only while Busy=0
//   Par_En     1 = append parity bit after the data bits
//   Par_Typ    0 = even parity (^data), 1 = odd parity (~^data)
//   Prescale   clocks per bit
//   Tx_Out     registered serial line, idle high
//   Busy       registered, high from accept edge until the frame completes
module uart_tx_frame #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESC_W    = 6
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic [DATA_WIDTH-1:0] P_Data,
  input  logic                  Data_Valid,
  input  logic                  Par_En,
  input  logic                  Par_Typ,
  input  logic [PRESC_W-1:0]    Prescale,
  output logic                  Tx_Out,
  output logic                  Busy
);

  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t                  state;
  logic [DATA_WIDTH-1:0]   shreg;
  logic                    par_en_q;
  logic                    par_bit_q;
  logic [PRESC_W-1:0]      presc_q;
  logic [PRESC_W-1:0]      cnt;
  logic [IDX_W-1:0]        idx;
  logic                    bit_done;

  assign bit_done = (cnt == presc_q - PRESC_W'(1));

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state     <= IDLE;
      shreg     <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      presc_q   <= PRESC_W'(1);
      cnt       <= '0;
      idx       <= '0;
      Tx_Out    <= 1'b1;
      Busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          Tx_Out <= 1'b1;
          Busy   <= 1'b0;
          cnt    <= '0;
          idx    <= '0;
          if (Data_Valid) begin
            shreg     <= P_Data;
            par_en_q  <= Par_En;
            par_bit_q <= Par_Typ ? ~^P_Data : ^P_Data;
            presc_q   <= (Prescale == '0) ? PRESC_W'(1) : Prescale;
            state     <= START;
            Tx_Out    <= 1'b0;
            Busy      <= 1'b1;
          end
        end

        START: begin
          if (bit_done) begin
            cnt    <= '0;
            idx    <= '0;
            state  <= DATA;
            Tx_Out <= shreg[0];
          end else begin
            cnt <= cnt + PRESC_W'(1);
          end
        end

        // The word is shifted right as each bit completes, so the next bit
        // to drive is always shreg[1] at the moment of the shift.
        DATA: begin
          if (bit_done) begin
            cnt <= '0;
            if (idx == IDX_W'(DATA_WIDTH - 1)) begin
              if (par_en_q) begin
                state  <= PARITY;
                Tx_Out <= par_bit_q;
              end else begin
                state  <= STOP;
                Tx_Out <= 1'b1;
              end
            end else begin
              idx    <= idx + IDX_W'(1);
              shreg  <= shreg >> 1;
              Tx_Out <= shreg[1];
            end
          end else begin
            cnt <= cnt + PRESC_W'(1);
          end
        end

        PARITY: begin
          if (bit_done) begin
            cnt    <= '0;
            state  <= STOP;
            Tx_Out <= 1'b1;
          end else begin
            cnt <= cnt + PRESC_W'(1);
          end
        end

        STOP: begin
          Tx_Out <= 1'b1;
          if (bit_done) begin
            cnt   <= '0;
            state <= IDLE;
            Busy  <= 1'b0;
          end else begin
            cnt <= cnt + PRESC_W'(1);
          end
        end

        default: begin
          state  <= IDLE;
          Tx_Out <= 1'b1;
          Busy   <= 1'b0;
          cnt    <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame: directed bench for uart_tx_frame (DATA_WIDTH=8, PRESC_W=6).
// Expected serial sequences are hand-written, first transmitted bit at the MSB.
module tb_uart_tx_frame;

  logic       Clk;
  logic       Rst;
  logic [7:0] P_Data;
  logic       Data_Valid;
  logic       Par_En;
  logic       Par_Typ;
  logic [5:0] Prescale;
  logic       Tx_Out;
  logic       Busy;

  int unsigned tests;
  int unsigned failed;

  uart_tx_frame #(
    .DATA_WIDTH(8),
    .PRESC_W   (6)
  ) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .P_Data    (P_Data),
    .Data_Valid(Data_Valid),
    .Par_En    (Par_En),
    .Par_Typ   (Par_Typ),
    .Prescale  (Prescale),
    .Tx_Out    (Tx_Out),
    .Busy      (Busy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Called at a negedge. Presents a request, lets the next posedge accept it,
  // then checks Tx_Out/Busy on every negedge of the frame and the idle cycle
  // after it. With hold=1, Data_Valid stays high and P_Data/Prescale are
  // changed right after the accept.
  task automatic run_frame(input string tag, input logic [7:0] data,
                           input logic pen, input logic typ,
                           input logic [5:0] presc, input int unsigned p_eff,
                           input logic [11:0] exp, input int unsigned n,
                           input logic hold, input logic [7:0] mid_data,
                           input logic [5:0] mid_presc);
    P_Data     = data;
    Par_En     = pen;
    Par_Typ    = typ;
    Prescale   = presc;
    Data_Valid = 1'b1;
    @(posedge Clk);
    for (int unsigned b = 0; b < n; b++) begin
      for (int unsigned c = 0; c < p_eff; c++) begin
        @(negedge Clk);
        if (b == 0 && c == 0) begin
          if (hold) begin
            P_Data   = mid_data;
            Prescale = mid_presc;
            Par_En   = ~pen;
          end else begin
            Data_Valid = 1'b0;
          end
        end
        chk($sformatf("%s tx b%0d c%0d", tag, b, c), Tx_Out, exp[n-1-b]);
        chk($sformatf("%s busy b%0d c%0d", tag, b, c), Busy, 1'b1);
      end
    end
    @(negedge Clk);
    chk($sformatf("%s idle tx", tag), Tx_Out, 1'b1);
    chk($sformatf("%s idle busy", tag), Busy, 1'b0);
  endtask

  initial begin
    tests      = 0;
    failed     = 0;
    Rst        = 1'b1;
    P_Data     = '0;
    Data_Valid = 1'b0;
    Par_En     = 1'b0;
    Par_Typ    = 1'b0;
    Prescale   = 6'd1;

    // 1. Reset, then idle for 20 cycles with no request.
    #3 Rst = 1'b0;
    #1;
    chk("reset tx", Tx_Out, 1'b1);
    chk("reset busy", Busy, 1'b0);
    repeat (3) @(negedge Clk);
    Rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clk);
      chk($sformatf("idle%0d tx", i), Tx_Out, 1'b1);
      chk($sformatf("idle%0d busy", i), Busy, 1'b0);
    end

    // 2. A5, even parity, P=1: 0,1,0,1,0,0,1,0,1,0,1
    run_frame("a5even", 8'hA5, 1'b1, 1'b0, 6'd1, 1, 12'b0_01010010101, 11,
              1'b0, 8'h00, 6'd0);

    // 3. A5, odd parity: parity bit becomes 1
    run_frame("a5odd", 8'hA5, 1'b1, 1'b1, 6'd1, 1, 12'b0_01010010111, 11,
              1'b0, 8'h00, 6'd0);

    // 4. 0F, no parity, P=4: 40-cycle frame
    run_frame("0fp4", 8'h0F, 1'b0, 1'b0, 6'd4, 4, 12'b00_0111100001, 10,
              1'b0, 8'h00, 6'd0);

    // 5. Data_Valid held; inputs change mid-frame. First frame keeps 55/P=1,
    //    the second is accepted on the first Busy=0 edge with C3/P=2.
    run_frame("hold55", 8'h55, 1'b0, 1'b0, 6'd1, 1, 12'b00_0101010101, 10,
              1'b1, 8'hC3, 6'd2);
    Par_En = 1'b0;
    run_frame("holdc3", 8'hC3, 1'b0, 1'b0, 6'd2, 2, 12'b00_0110000111, 10,
              1'b0, 8'h00, 6'd0);

    // 6. Reset during data bit 3 of an F0 frame (P=2): bit 3 is low.
    P_Data     = 8'hF0;
    Par_En     = 1'b0;
    Par_Typ    = 1'b0;
    Prescale   = 6'd2;
    Data_Valid = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    Data_Valid = 1'b0;
    repeat (8) @(negedge Clk);
    chk("f0 bit3 tx", Tx_Out, 1'b0);
    chk("f0 bit3 busy", Busy, 1'b1);
    Rst = 1'b0;
    #1;
    chk("midrst tx", Tx_Out, 1'b1);
    chk("midrst busy", Busy, 1'b0);
    repeat (2) @(negedge Clk);
    Rst = 1'b1;
    @(negedge Clk);
    chk("postrst tx", Tx_Out, 1'b1);
    chk("postrst busy", Busy, 1'b0);

    // 3C, odd parity, Prescale=0 acting as 1: 0,0,0,1,1,1,1,0,0,1,1
    run_frame("3cp0", 8'h3C, 1'b1, 1'b1, 6'd0, 1, 12'b0_00011110011, 11,
              1'b0, 8'h00, 6'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, %0d failed so far", failed);
    $fatal(1, "timeout");
  end

endmodule
